// File: rtl/softmax_pkg.sv
// Shared constants and length-mode helpers for the softmax row packer feeding the 64-lane max tree.
package softmax_pkg;

  localparam int              DATA_W    = 16;
  localparam int              LANES     = 64;
  localparam logic [15:0]     PAD_VALUE = 16'h8000;

  localparam logic [3:0] LEN16 = 4'b0001;
  localparam logic [3:0] LEN32 = 4'b0010;
  localparam logic [3:0] LEN64 = 4'b0100;

  // Unknown encodings fall back to 64-mode so a bad code never splits a row.
  function automatic logic [3:0] legal_mode(input logic [3:0] m);
    return (m == LEN16 || m == LEN32 || m == LEN64) ? m : LEN64;
  endfunction

  function automatic logic [6:0] seg_size(input logic [3:0] m);
    case (m)
      LEN16:   return 7'd16;
      LEN32:   return 7'd32;
      default: return 7'd64;
    endcase
  endfunction

  function automatic logic [1:0] last_seg(input logic [3:0] m);
    case (m)
      LEN16:   return 2'd3;
      LEN32:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/softmax_row_packer.sv
// Packs a stream of signed softmax elements into padded 64-lane vectors for the max tree,
// with an assembly buffer in front of an output register so consecutive vectors stream back-to-back.
module softmax_row_packer #(
  parameter int                DATA_W    = softmax_pkg::DATA_W,
  parameter int                LANES     = softmax_pkg::LANES,
  parameter logic [DATA_W-1:0] PAD_VALUE = softmax_pkg::PAD_VALUE
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic signed [DATA_W-1:0]  i_data,
  input  logic                      i_last,
  input  logic [3:0]                i_length_mode,
  input  logic                      i_flush,
  input  logic                      i_en,
  output logic                      o_vec_valid,
  output logic                      o_en,
  output logic [3:0]                o_length_mode,
  output logic [LANES-1:0]          o_valid,
  output logic [LANES*DATA_W-1:0]   o_in_flat,
  output logic [1:0]                o_err
);
  import softmax_pkg::*;

  localparam int LW = $clog2(LANES);

  logic [LANES-1:0][DATA_W-1:0] asm_data_q, asm_data_d, out_data_q;
  logic [LANES-1:0]             asm_vld_q, asm_vld_d, out_vld_q;
  logic                         asm_full_q, asm_act_q, out_vv_q;
  logic [3:0]                   asm_mode_q, out_mode_q, cur_mode;
  logic [1:0]                   seg_q, err_q, seg_last;
  logic [LW-1:0]                lane_q;
  logic [6:0]                   seg_s, wr_lane;
  logic                         accept, consume, first, seg_end, row_close, overrun, close, xfer;

  assign o_ready   = ~asm_full_q;
  assign accept    = i_valid & ~asm_full_q;
  assign consume   = out_vv_q & i_en;
  assign first     = accept & ~asm_act_q;
  assign cur_mode  = first ? legal_mode(i_length_mode) : asm_mode_q;
  assign seg_s     = seg_size(cur_mode);
  assign seg_last  = last_seg(cur_mode);
  assign wr_lane   = 7'(seg_q) * seg_s + 7'(lane_q);
  assign seg_end   = (7'(lane_q) == seg_s - 7'd1);
  assign row_close = accept & (i_last | seg_end);
  assign overrun   = accept & ~i_last & seg_end;
  // A flush only closes when something has been assembled, including the element arriving with it.
  assign close     = (row_close & (seg_q == seg_last)) |
                     (i_flush & ~asm_full_q & (asm_act_q | accept));
  assign xfer      = (close | asm_full_q) & (~out_vv_q | consume);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic hit;
    assign hit           = accept && (wr_lane == 7'(g));
    assign asm_data_d[g] = hit ? i_data : asm_data_q[g];
    assign asm_vld_d[g]  = hit | asm_vld_q[g];
  end

  // Stage p0 -> p1: assembly buffer and transfer into the output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      asm_data_q <= {LANES{PAD_VALUE}};
      asm_vld_q  <= '0;
      asm_full_q <= 1'b0;
      asm_act_q  <= 1'b0;
      asm_mode_q <= '0;
      seg_q      <= '0;
      lane_q     <= '0;
      out_data_q <= {LANES{PAD_VALUE}};
      out_vld_q  <= '0;
      out_mode_q <= '0;
      out_vv_q   <= 1'b0;
      err_q      <= '0;
    end else begin
      if (first) begin
        asm_act_q  <= 1'b1;
        asm_mode_q <= cur_mode;
        if (legal_mode(i_length_mode) != i_length_mode) err_q[0] <= 1'b1;
      end
      if (overrun) err_q[1] <= 1'b1;
      if (xfer) begin
        out_data_q <= asm_data_d;
        out_vld_q  <= asm_vld_d;
        out_mode_q <= cur_mode;
        out_vv_q   <= 1'b1;
        asm_data_q <= {LANES{PAD_VALUE}};
        asm_vld_q  <= '0;
        asm_act_q  <= 1'b0;
        asm_full_q <= 1'b0;
        seg_q      <= '0;
        lane_q     <= '0;
      end else begin
        if (consume) out_vv_q <= 1'b0;
        asm_data_q <= asm_data_d;
        asm_vld_q  <= asm_vld_d;
        if (close) begin
          asm_full_q <= 1'b1;
          seg_q      <= '0;
          lane_q     <= '0;
        end else if (row_close) begin
          seg_q  <= seg_q + 2'd1;
          lane_q <= '0;
        end else if (accept) begin
          lane_q <= lane_q + LW'(1);
        end
      end
    end
  end

  assign o_vec_valid   = out_vv_q;
  assign o_en          = i_en;
  assign o_length_mode = out_mode_q;
  assign o_valid       = out_vld_q;
  assign o_in_flat     = out_data_q;
  assign o_err         = err_q;

endmodule
